// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle bit positions used by the decoder and the ID/EX register.
package id_ex_stage_pkg;

  localparam int EX_W  = 2;
  localparam int M_W   = 3;
  localparam int WB_W  = 2;
  localparam int REG_W = 5;

  localparam int EX_REG_DST    = 1;
  localparam int EX_ALU_SRC    = 0;
  localparam int M_BRANCH      = 2;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;
  localparam int WB_MEM_TO_REG = 1;
  localparam int WB_REG_WRITE  = 0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// Combinational; a load into register 0 never creates a hazard.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_reg_dst,
  input  logic             id_mem_write,
  input  logic             id_branch,
  output logic             hazard
);

  logic rt_is_source;

  // rt is read as a source by R-type, store and branch instructions
  assign rt_is_source = id_reg_dst | id_mem_write | id_branch;

  assign hazard = ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | ((ex_rt == id_rt) & rt_is_source));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// One-cycle latency; bubbles are counted in a saturating counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EX_W-1:0]   id_ex,
  input  logic [M_W-1:0]    id_m,
  input  logic [WB_W-1:0]   id_wb,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  output logic [EX_W-1:0]   ex_ex,
  output logic [M_W-1:0]    ex_m,
  output logic [WB_W-1:0]   ex_wb,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [REG_W-1:0]  ex_dest,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);

  logic hazard;
  logic bubble;

  hazard_detect u_hazard_detect (
    .ex_mem_read  (ex_m[M_MEM_READ]),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_reg_dst   (id_ex[EX_REG_DST]),
    .id_mem_write (id_m[M_MEM_WRITE]),
    .id_branch    (id_m[M_BRANCH]),
    .hazard       (hazard)
  );

  // A flush already discards the ID instruction, so it masks the stall
  assign stall       = hazard & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign bubble      = flush | hazard;

  assign ex_dest = ex_ex[EX_REG_DST] ? ex_rd : ex_rt;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex_ex      <= '0;
      ex_m       <= '0;
      ex_wb      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else begin
      ex_ex      <= id_ex;
      ex_m       <= id_m;
      ex_wb      <= id_wb;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bubble && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural pipeline-register model.
module tb_id_ex_stage;

  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic [1:0]    ex;
    logic [2:0]    m;
    logic [1:0]    wb;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
  } stage_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  stage_t id;
  stage_t got;
  stage_t mdl;
  logic [CNT_W-1:0] mdl_cnt;

  logic [1:0]       ex_ex;
  logic [2:0]       ex_m;
  logic [1:0]       ex_wb;
  logic [DW-1:0]    ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]       ex_rs, ex_rt, ex_rd, ex_dest;
  logic             stall, pc_write, if_id_write;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_ex(id.ex), .id_m(id.m), .id_wb(id.wb),
    .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm(id.imm), .id_pc4(id.pc4),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .flush(flush),
    .ex_ex(ex_ex), .ex_m(ex_m), .ex_wb(ex_wb),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_dest(ex_dest),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .bubble_count(bubble_count)
  );

  assign got = {ex_ex, ex_m, ex_wb, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd};

  // Reference: a load in EX blocks an ID instruction that reads the loaded register
  function automatic logic model_hazard();
    logic load_in_ex = mdl.m[1];
    logic reads_rt   = id.ex[1] || id.m[0] || id.m[2];
    if (!load_in_ex || mdl.rt == 5'd0) return 1'b0;
    return (id.rs == mdl.rt) || (reads_rt && id.rt == mdl.rt);
  endfunction

  // Advance the model with the current inputs, then clock the DUT
  task automatic tick();
    if (reset) begin
      mdl = '0;
      mdl_cnt = '0;
    end else if (flush || model_hazard()) begin
      mdl = '0;
      if (mdl_cnt != CMAX) mdl_cnt = mdl_cnt + 1'b1;
    end else begin
      mdl = id;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] ex, input logic [2:0] m, input logic [1:0] wb,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id.ex = ex; id.m = m; id.wb = wb;
    id.rs = rs; id.rt = rt; id.rd = rd;
    id.rs_data = $urandom; id.rt_data = $urandom;
    id.imm = $urandom; id.pc4 = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_instr(2'b11, 3'b111, 2'b11, 5'd9, 5'd9, 5'd9);
    do_reset();
    id = '0;
    #1;
    checks++;
    if (got !== '0) begin
      $display("FAIL reset_regs got=%h want=0", got); errors++;
    end
    checks++;
    if (bubble_count !== '0) begin
      $display("FAIL reset_count got=%0d want=0", bubble_count); errors++;
    end
    checks++;
    if ({stall, pc_write, if_id_write} !== 3'b011) begin
      $display("FAIL reset_ctrl got=%b want=011", {stall, pc_write, if_id_write}); errors++;
    end
  endtask

  task automatic test_rtype();
    do_reset();
    set_instr(2'b10, 3'b000, 2'b01, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (ex_ex !== 2'b10 || ex_dest !== 5'd3 || stall !== 1'b0) begin
      $display("FAIL rtype got ex=%b dest=%0d stall=%b want ex=10 dest=3 stall=0", ex_ex, ex_dest, stall);
      errors++;
    end
    checks++;
    if (ex_rs_data !== id.rs_data || ex_pc4 !== id.pc4 || ex_wb !== 2'b01) begin
      $display("FAIL rtype_data got rs=%h pc4=%h wb=%b want rs=%h pc4=%h wb=01",
               ex_rs_data, ex_pc4, ex_wb, id.rs_data, id.pc4);
      errors++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(2'b01, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
    tick();
    set_instr(2'b10, 3'b000, 2'b01, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if ({stall, pc_write, if_id_write} !== 3'b100) begin
      $display("FAIL loaduse_stall got=%b want=100", {stall, pc_write, if_id_write}); errors++;
    end
    tick();
    checks++;
    if (ex_m !== 3'b000 || bubble_count !== 4'd1 || stall !== 1'b0) begin
      $display("FAIL loaduse_bubble got m=%b cnt=%0d stall=%b want m=000 cnt=1 stall=0",
               ex_m, bubble_count, stall);
      errors++;
    end
    tick();
    checks++;
    if (ex_rs !== 5'd5 || ex_rd !== 5'd7 || ex_ex !== 2'b10 || bubble_count !== 4'd1) begin
      $display("FAIL loaduse_resume got rs=%0d rd=%0d ex=%b cnt=%0d want rs=5 rd=7 ex=10 cnt=1",
               ex_rs, ex_rd, ex_ex, bubble_count);
      errors++;
    end
  endtask

  task automatic test_rt_not_source();
    do_reset();
    set_instr(2'b01, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
    tick();
    set_instr(2'b01, 3'b000, 2'b01, 5'd4, 5'd5, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0 || pc_write !== 1'b1) begin
      $display("FAIL addi_nostall got stall=%b pc_write=%b want 0 1", stall, pc_write); errors++;
    end
    id.m = 3'b001;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL sw_stall got stall=%b want 1", stall); errors++;
    end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    set_instr(2'b01, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
    tick();
    set_instr(2'b01, 3'b001, 2'b00, 5'd4, 5'd5, 5'd0);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
      $display("FAIL flush_stall got stall=%b pc_write=%b want 0 1", stall, pc_write); errors++;
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (ex_m !== 3'b000 || got !== '0 || bubble_count !== 4'd1) begin
      $display("FAIL flush_bubble got m=%b cnt=%0d want m=000 cnt=1", ex_m, bubble_count); errors++;
    end
  endtask

  task automatic test_reg_zero_saturate();
    do_reset();
    set_instr(2'b01, 3'b010, 2'b11, 5'd3, 5'd0, 5'd0);
    tick();
    set_instr(2'b10, 3'b001, 2'b01, 5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL reg0_stall got %b want 0", stall); errors++;
    end
    flush = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (bubble_count !== CMAX) begin
      $display("FAIL count_reach_max got %0d want %0d", bubble_count, CMAX); errors++;
    end
    tick();
    flush = 1'b0;
    checks++;
    if (bubble_count !== CMAX) begin
      $display("FAIL count_saturate got %0d want %0d", bubble_count, CMAX); errors++;
    end
  endtask

  task automatic test_reset_during_stall();
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_instr(2'b01, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
    tick();
    set_instr(2'b10, 3'b000, 2'b01, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL pre_reset_stall got %b want 1", stall); errors++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (got !== '0 || bubble_count !== '0 || pc_write !== 1'b1 || stall !== 1'b0) begin
      $display("FAIL reset_in_stall got regs=%h cnt=%0d pc_write=%b want 0 0 1",
               got, bubble_count, pc_write);
      errors++;
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_instr(2'($urandom), 3'($urandom), 2'($urandom),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (stall !== (model_hazard() && !flush) || pc_write !== !stall || if_id_write !== !stall) begin
        if (bad < 10) $display("FAIL rand_ctrl n=%0d got stall=%b pc_write=%b want stall=%b",
                               n, stall, pc_write, model_hazard() && !flush);
        errors++; bad++;
      end
      tick();
      checks++;
      if (got !== mdl || bubble_count !== mdl_cnt ||
          ex_dest !== (mdl.ex[1] ? mdl.rd : mdl.rt)) begin
        if (bad < 10) $display("FAIL rand_regs n=%0d got=%h cnt=%0d dest=%0d want=%h cnt=%0d",
                               n, got, bubble_count, ex_dest, mdl, mdl_cnt);
        errors++; bad++;
      end
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    id = '0;
    mdl = '0;
    mdl_cnt = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_load_use();
    test_rt_not_source();
    test_flush_hazard();
    test_reg_zero_saturate();
    test_reset_during_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
